// File: rtl/lcd_hd44780_responder.sv
// LCD-module side of an HD44780-style parallel bus: decodes strobed writes,
// keeps a DDRAM image, cursor address and display flags, and emulates busy.
module lcd_hd44780_responder #(
  parameter int BUSY_CYCLES    = 40,
  parameter int MEM_DEPTH_LOG2 = 7
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic [7:0]                LCD_DATA,
  input  logic                      LCD_RS,
  input  logic                      LCD_RW,
  input  logic                      LCD_EN,
  output logic [7:0]                oRD_DATA,
  output logic                      oBUSY,
  output logic [MEM_DEPTH_LOG2-1:0] oADDR,
  output logic                      oDISP_ON,
  output logic                      oCURSOR_ON,
  output logic                      oBLINK_ON,
  output logic                      oINC,
  output logic                      oCMD_VALID,
  output logic                      oCHAR_VALID,
  output logic [7:0]                oERR_CNT,
  input  logic [MEM_DEPTH_LOG2-1:0] iDBG_ADDR,
  output logic [7:0]                oDBG_DATA
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CNT_W-1:0]          CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [MEM_DEPTH_LOG2-1:0] ADDR_ONE = MEM_DEPTH_LOG2'(1);
  localparam logic [MEM_DEPTH_LOG2-1:0] PTR_LAST = '1;
  localparam logic [7:0]                BLANK    = 8'h20;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_CLEAR} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            busy_cnt;
  logic [MEM_DEPTH_LOG2-1:0]   clr_ptr;
  logic                        en_q, rs_q, rw_q;
  logic [7:0]                  data_q;
  logic                        strobe;
  logic [MEM_DEPTH_LOG2-1:0]   addr_step;
  logic [7:0]                  ddram [DEPTH];

  logic                        mem_we;
  logic [MEM_DEPTH_LOG2-1:0]   mem_waddr;
  logic [7:0]                  mem_wdata;

  // Strobe fires on the falling edge of EN; the word is what was held while EN was high.
  assign strobe    = en_q & ~LCD_EN;
  assign oBUSY     = (state != S_IDLE);
  assign addr_step = oINC ? (oADDR + ADDR_ONE) : (oADDR - ADDR_ONE);
  assign oDBG_DATA = ddram[iDBG_ADDR];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = oADDR;
    mem_wdata = data_q;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr;
      mem_wdata = BLANK;
    end else if (state == S_IDLE && strobe && !rw_q && rs_q) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the DDRAM array has no reset; the post-reset CLEAR sweep initialises its contents.
  always_ff @(posedge iCLK) begin
    if (mem_we) ddram[mem_waddr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b0;
      data_q      <= '0;
      state       <= S_CLEAR;
      busy_cnt    <= '0;
      clr_ptr     <= '0;
      oADDR       <= '0;
      oDISP_ON    <= 1'b0;
      oCURSOR_ON  <= 1'b0;
      oBLINK_ON   <= 1'b0;
      oINC        <= 1'b1;
      oCMD_VALID  <= 1'b0;
      oCHAR_VALID <= 1'b0;
      oERR_CNT    <= '0;
      oRD_DATA    <= '0;
    end else begin
      en_q        <= LCD_EN;
      rs_q        <= LCD_RS;
      rw_q        <= LCD_RW;
      data_q      <= LCD_DATA;
      oCMD_VALID  <= 1'b0;
      oCHAR_VALID <= 1'b0;
      oRD_DATA    <= (LCD_EN && LCD_RW) ? (LCD_RS ? ddram[oADDR] : 8'({oBUSY, oADDR})) : '0;

      // A write landing while not idle (including the last busy cycle) is a protocol error.
      if (strobe && !rw_q && state != S_IDLE && oERR_CNT != 8'hFF)
        oERR_CNT <= oERR_CNT + 8'd1;

      case (state)
        S_CLEAR: begin
          if (clr_ptr == PTR_LAST) begin
            clr_ptr  <= '0;
            oADDR    <= '0;
            state    <= S_BUSY;
            busy_cnt <= CNT_LOAD;
          end else begin
            clr_ptr <= clr_ptr + ADDR_ONE;
          end
        end
        S_BUSY: begin
          if (busy_cnt == '0) state <= S_IDLE;
          else                busy_cnt <= busy_cnt - 1'b1;
        end
        default: begin
          if (strobe) begin
            if (rw_q) begin
              if (rs_q) oADDR <= addr_step;
            end else if (rs_q) begin
              oADDR       <= addr_step;
              oCHAR_VALID <= 1'b1;
              state       <= S_BUSY;
              busy_cnt    <= CNT_LOAD;
            end else begin
              oCMD_VALID <= 1'b1;
              state      <= S_BUSY;
              busy_cnt   <= CNT_LOAD;
              casez (data_q)
                8'b1???????: oADDR <= MEM_DEPTH_LOG2'(data_q[6:0]);
                8'b0001????: begin
                  if (!data_q[3]) oADDR <= data_q[2] ? (oADDR + ADDR_ONE) : (oADDR - ADDR_ONE);
                end
                8'b00001???: begin
                  oDISP_ON   <= data_q[2];
                  oCURSOR_ON <= data_q[1];
                  oBLINK_ON  <= data_q[0];
                end
                8'b000001??: oINC  <= data_q[1];
                8'b0000001?: oADDR <= '0;
                8'b00000001: begin
                  state   <= S_CLEAR;
                  clr_ptr <= '0;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder: bus-level stimulus with a scoreboard
// of expected post-pulse state, plus direct checks of busy timing and DDRAM.
module tb_lcd_hd44780_responder;

  localparam int BUSY_CYCLES = 40;
  localparam int INIT_BUSY   = 128 + BUSY_CYCLES;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN;
  logic [7:0] oRD_DATA;
  logic       oBUSY;
  logic [6:0] oADDR;
  logic       oDISP_ON, oCURSOR_ON, oBLINK_ON, oINC;
  logic       oCMD_VALID, oCHAR_VALID;
  logic [7:0] oERR_CNT;
  logic [6:0] iDBG_ADDR;
  logic [7:0] oDBG_DATA;

  lcd_hd44780_responder #(.BUSY_CYCLES(BUSY_CYCLES), .MEM_DEPTH_LOG2(7)) dut (
    .iCLK(iCLK), .iRST(iRST), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .oRD_DATA(oRD_DATA), .oBUSY(oBUSY), .oADDR(oADDR),
    .oDISP_ON(oDISP_ON), .oCURSOR_ON(oCURSOR_ON), .oBLINK_ON(oBLINK_ON), .oINC(oINC),
    .oCMD_VALID(oCMD_VALID), .oCHAR_VALID(oCHAR_VALID), .oERR_CNT(oERR_CNT),
    .iDBG_ADDR(iDBG_ADDR), .oDBG_DATA(oDBG_DATA)
  );

  always #5 iCLK = ~iCLK;

  typedef enum logic {EV_CMD, EV_CHAR} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [6:0] addr;
    logic       inc, disp, cur, blink;
  } exp_t;

  exp_t sb[$];
  exp_t mon_act, mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n;

  // Instruction table: command byte and the address/flags expected after it.
  logic [7:0] cmd_tab  [12] = '{8'h06, 8'h14, 8'h14, 8'h10, 8'h1C, 8'h0F,
                                8'h08, 8'h02, 8'h20, 8'h85, 8'h00, 8'h02};
  logic [6:0] addr_tab [12] = '{7'd126, 7'd127, 7'd0, 7'd127, 7'd127, 7'd127,
                                7'd127, 7'd0, 7'd0, 7'd5, 7'd5, 7'd0};
  logic [3:0] flag_tab [12] = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111,
                                4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input ev_kind_t k, input logic [6:0] a, input logic [3:0] f);
    exp_t e;
    e.kind  = k;
    e.addr  = a;
    e.inc   = f[3];
    e.disp  = f[2];
    e.cur   = f[1];
    e.blink = f[0];
    sb.push_back(e);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge iCLK); #1;
    LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d; LCD_EN = 1'b1;
    repeat (2) @(posedge iCLK);
    #1 LCD_EN = 1'b0;
  endtask

  task automatic bus_read_check(input logic rs, input logic [7:0] exp, input string name);
    @(posedge iCLK); #1;
    LCD_RS = rs; LCD_RW = 1'b1; LCD_EN = 1'b1;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    check(name, oRD_DATA, exp);
    @(posedge iCLK); #1 LCD_EN = 1'b0;
    repeat (2) @(negedge iCLK);
    check({name, "_idle_zero"}, oRD_DATA, 8'h00);
    LCD_RW = 1'b0;
  endtask

  // Counts negedges with oBUSY high, bounded so a stuck flag still ends the run.
  task automatic measure_busy(output int cnt);
    int guard;
    cnt   = 0;
    guard = 0;
    @(negedge iCLK);
    while (!oBUSY && guard < 4) begin
      @(negedge iCLK);
      guard++;
    end
    while (oBUSY && cnt < 2000) begin
      cnt++;
      @(negedge iCLK);
    end
  endtask

  task automatic dbg_check(input logic [6:0] a, input logic [7:0] exp, input string name);
    iDBG_ADDR = a;
    #1;
    check(name, oDBG_DATA, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, oBUSY, 1'b1);
    check({tag, "_addr"}, oADDR, 7'd0);
    check({tag, "_inc"}, oINC, 1'b1);
    check({tag, "_flags"}, {oDISP_ON, oCURSOR_ON, oBLINK_ON}, 3'b000);
    check({tag, "_pulses"}, {oCMD_VALID, oCHAR_VALID}, 2'b00);
    check({tag, "_err"}, oERR_CNT, 8'd0);
    check({tag, "_rd"}, oRD_DATA, 8'd0);
  endtask

  // Monitor: every pulse pops one expected entry and compares the post-pulse state.
  always @(negedge iCLK) begin
    if (!iRST && (oCMD_VALID || oCHAR_VALID)) begin
      mon_act.kind  = oCHAR_VALID ? EV_CHAR : EV_CMD;
      mon_act.addr  = oADDR;
      mon_act.inc   = oINC;
      mon_act.disp  = oDISP_ON;
      mon_act.cur   = oCURSOR_ON;
      mon_act.blink = oBLINK_ON;
      if (sb.size() == 0) begin
        check("unexpected_pulse", {oCMD_VALID, oCHAR_VALID}, 2'b00);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_event", 32'(mon_act), 32'(mon_exp));
        check("sb_single_pulse", {oCMD_VALID, oCHAR_VALID},
              (mon_exp.kind == EV_CHAR) ? 2'b01 : 2'b10);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b1; LCD_DATA = '0; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_EN = 1'b0; iDBG_ADDR = '0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check_reset_values("reset");

    @(posedge iCLK); #1 iRST = 1'b0;
    measure_busy(n);
    check("init_busy_cycles", n, INIT_BUSY);
    check("init_addr", oADDR, 7'd0);
    check("init_err", oERR_CNT, 8'd0);
    dbg_check(7'd0, 8'h20, "init_ddram_0");
    dbg_check(7'd64, 8'h20, "init_ddram_64");
    dbg_check(7'd127, 8'h20, "init_ddram_127");

    // Display on, cursor on, blink off.
    push_exp(EV_CMD, 7'd0, 4'b1110);
    bus_write(1'b0, 8'h0E);
    measure_busy(n);
    check("cmd_busy_cycles", n, BUSY_CYCLES);

    push_exp(EV_CHAR, 7'd1, 4'b1110);
    bus_write(1'b1, 8'h41);
    measure_busy(n);
    dbg_check(7'd0, 8'h41, "ddram0_A");
    check("addr_after_A", oADDR, 7'd1);

    // Wrap upward at the top of DDRAM.
    push_exp(EV_CMD, 7'd127, 4'b1110);
    bus_write(1'b0, 8'hFF);
    measure_busy(n);
    push_exp(EV_CHAR, 7'd0, 4'b1110);
    bus_write(1'b1, 8'h42);
    measure_busy(n);
    dbg_check(7'd127, 8'h42, "ddram127_B");

    // Decrement mode, wrap downward from 0.
    push_exp(EV_CMD, 7'd0, 4'b0110);
    bus_write(1'b0, 8'h04);
    measure_busy(n);
    push_exp(EV_CHAR, 7'd127, 4'b0110);
    bus_write(1'b1, 8'h43);
    bus_write(1'b1, 8'h41);
    bus_read_check(1'b0, 8'hFF, "busy_flag_read");
    check("err_after_busy_write", oERR_CNT, 8'd1);
    check("addr_after_busy_write", oADDR, 7'd127);
    dbg_check(7'd127, 8'h42, "ddram127_unchanged");
    dbg_check(7'd0, 8'h43, "ddram0_C");
    measure_busy(n);

    // Data read in IDLE returns DDRAM[addr] and steps the address without busy.
    bus_read_check(1'b1, 8'h42, "data_read");
    check("addr_after_data_read", oADDR, 7'd126);
    check("busy_after_data_read", oBUSY, 1'b0);

    for (int i = 0; i < 12; i++) begin
      push_exp(EV_CMD, addr_tab[i], flag_tab[i]);
      bus_write(1'b0, cmd_tab[i]);
      measure_busy(n);
    end

    // Clear, a write during CLEAR, then reset partway through.
    push_exp(EV_CMD, 7'd0, 4'b1000);
    bus_write(1'b0, 8'h01);
    bus_write(1'b1, 8'h55);
    repeat (44) @(negedge iCLK);
    check("clear_busy", oBUSY, 1'b1);
    check("err_during_clear", oERR_CNT, 8'd2);
    @(posedge iCLK); #1 iRST = 1'b1;
    @(negedge iCLK);
    check_reset_values("midclear_reset");
    @(posedge iCLK); #1 iRST = 1'b0;
    measure_busy(n);
    check("reclear_busy_cycles", n, INIT_BUSY);
    for (int a = 0; a < 128; a++) dbg_check(7'(a), 8'h20, "reclear_ddram");
    check("reclear_err", oERR_CNT, 8'd0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
